pulse_level_gen: RTL and testbench
==================================

// Module: pulse_level_gen
// PURPOSE
//  Converts single-cycle event pulses into clean level pulses. Each output pulse is high for exactly
//  HIGH_CYCLES cycles and is followed by at least GAP_CYCLES low cycles.
//  A downstream posedge detector therefore sees exactly one rising edge per accepted event.
//  Events that arrive while an output pulse is in progress are counted and replayed back-to-back.
//  Sits between event sources (handshake completions) and level-sensitive consumers and edge detectors.
// PARAMETERS
//  HIGH_CYCLES  4  cycles level_out is held high per event; >=1
//  GAP_CYCLES   2  minimum low cycles after each high phase; >=1
//  PEND_W       4  width of the pending-event counter; saturates at 2**PEND_W-1
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  pulse_in   in   1       event strobe; every cycle sampled high counts as one event
//  level_out  out  1       registered stretched level
//  busy       out  1       1 while the FSM is not in IDLE
//  pend_cnt   out  PEND_W  number of queued events not yet replayed
//  overflow   out  1       sticky; set when an event is lost because pend_cnt is saturated
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): state=IDLE, level_out=0, busy=0, pend_cnt=0, overflow=0.
//    Any in-progress pulse and all pending events are dropped. Reset takes priority over pulse_in.
//  - FSM states: IDLE, HIGH, GAP. A down-counter cnt is sized for max(HIGH_CYCLES, GAP_CYCLES).
//    level_out = (state==HIGH); busy = (state!=IDLE). Both are registered, with no combinational path
//    from pulse_in.
//  - IDLE:
//    - pulse_in=1 -> HIGH next cycle, cnt=HIGH_CYCLES-1.
//    - Latency: level_out rises 1 cycle after pulse_in is sampled.
//  - HIGH:
//    - cnt decrements each cycle. At cnt==0 -> GAP, cnt=GAP_CYCLES-1.
//    - pulse_in=1 -> pend_cnt+1.
//  - GAP:
//    - cnt decrements each cycle. pulse_in=1 -> pend_cnt+1, except in the last GAP cycle.
//    - Last GAP cycle (cnt==0):
//      - pend_cnt>0 or pulse_in=1 -> HIGH, cnt=HIGH_CYCLES-1. Otherwise -> IDLE.
//      - pend_cnt>0 and pulse_in=0: pend_cnt-1.
//      - pend_cnt>0 and pulse_in=1: pend_cnt unchanged (+1 and -1 in the same cycle).
//      - pend_cnt==0 and pulse_in=1: pend_cnt stays 0; the new event is consumed directly.
//  - Saturation: an increment at pend_cnt==2**PEND_W-1 is dropped and overflow is set to 1.
//    overflow is cleared only by rst.
//  - There is no other simultaneous-event case; at most one increment and one decrement occur per cycle.
// CONFIGURATION
//  - PULSE_LEVEL_RETRIGGER_EN defined:
//    - pulse_in=1 while in HIGH reloads cnt=HIGH_CYCLES-1 and does not touch pend_cnt.
//    - The high phase is extended: it ends HIGH_CYCLES cycles after the last retrigger.
//    - pulse_in=1 during GAP is queued as above.
//  - Macro undefined: all pulses arriving in HIGH are queued as described in BEHAVIOUR.
// STRUCTURE
//  - pulse_level_pkg holds:
//    - typedef enum logic [1:0] {IDLE, HIGH, GAP} pl_state_t;
//    - function cnt_w(hi, gap) returning $clog2(max(hi, gap) + 1).
//  - One sub-module, pl_sat_cnt: PEND_W-bit saturating up/down counter with inc, dec, value and
//    overflow_sticky.
//  - The FSM and cnt stay in pulse_level_gen.
//  - Elaboration assertions: HIGH_CYCLES>=1, GAP_CYCLES>=1, PEND_W>=1.
// TESTING (defaults; cycle n = nth rising edge after reset release)
//  1. Single pulse at cycle 10 -> level_out=1 in cycles 11-14; 0 in 15-16 (GAP).
//     busy=1 in 11-16, busy=0 in 17. pend_cnt=0 throughout.
//  2. Pulses at cycles 10, 12, 13 -> level_out high in 11-14, 17-20 and 23-26.
//     pend_cnt: 1 after cycle 12, 2 after cycle 13, 1 at cycle 17, 0 at cycle 23. overflow=0.
//  3. pulse_in held high for cycles 10-29 -> pend_cnt saturates at 15, overflow=1.
//     The bench then drains 15 replays; overflow stays 1 after the drain.
//  4. Pulse at cycle 10, second pulse at cycle 16 (last GAP cycle) -> level_out high 11-14, low 15-16,
//     high 17-20. pend_cnt stays 0.
//  5. Pulse at cycle 10 and 11, rst=1 at cycle 12 -> at cycle 13: level_out=0, busy=0, pend_cnt=0,
//     overflow=0. No replay follows.
//  6. With PULSE_LEVEL_RETRIGGER_EN: pulses at cycles 10 and 13 -> level_out high in 11-17, low in 18-19.
//     pend_cnt stays 0.

Source files
------------

// File: rtl/pulse_level_pkg.sv
// Shared types and sizing helpers for the pulse-to-level stretcher.
package pulse_level_pkg;

    typedef enum logic [1:0] {IDLE, HIGH, GAP} pl_state_t;

    // Width of a down-counter that must hold values up to max(hi, gap).
    function automatic int unsigned cnt_w(int unsigned hi, int unsigned gap);
        int unsigned m;
        m = (hi > gap) ? hi : gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pulse_level_gen_if.sv
// Event-in / level-out bundle of pulse_level_gen; master is the event source side.
interface pulse_level_gen_if #(
    parameter int unsigned PEND_W = 4
);
    logic              pulse_in;
    logic              level_out;
    logic              busy;
    logic [PEND_W-1:0] pend_cnt;
    logic              overflow;

    modport master (
        output pulse_in,
        input  level_out,
        input  busy,
        input  pend_cnt,
        input  overflow
    );

    modport slave (
        input  pulse_in,
        output level_out,
        output busy,
        output pend_cnt,
        output overflow
    );
endinterface

// File: rtl/pl_sat_cnt.sv
// Saturating up/down counter holding queued events; sticky flag records dropped increments.
module pl_sat_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             overflow_sticky
);
    localparam logic [WIDTH-1:0] MaxVal = '1;

    logic [WIDTH-1:0] value_q, value_d;
    logic             ovf_q, ovf_d;

    // Simultaneous inc and dec cancel out, so they can never overflow.
    always_comb begin
        value_d = value_q;
        ovf_d   = ovf_q;
        if (inc && !dec) begin
            if (value_q == MaxVal) begin
                ovf_d = 1'b1;
            end else begin
                value_d = value_q + 1'b1;
            end
        end else if (dec && !inc && (value_q != '0)) begin
            value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value           = value_q;
    assign overflow_sticky = ovf_q;
endmodule

// File: rtl/pulse_level_gen.sv
// Stretches event strobes into HIGH_CYCLES-wide level pulses separated by GAP_CYCLES low cycles.
// Optional PULSE_LEVEL_RETRIGGER_EN: events during the high phase extend it instead of queueing.
module pulse_level_gen
    import pulse_level_pkg::*;
#(
    parameter int unsigned HIGH_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned PEND_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    pulse_level_gen_if.slave         bus
);
    localparam int unsigned CW = cnt_w(HIGH_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] HiLoad  = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] GapLoad = CW'(GAP_CYCLES - 1);

    if (HIGH_CYCLES < 1) begin : g_bad_high
        $error("HIGH_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("GAP_CYCLES must be >= 1");
    end
    if (PEND_W < 1) begin : g_bad_pend
        $error("PEND_W must be >= 1");
    end

    pl_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              level_q, busy_q;
    logic              inc, dec;
    logic [PEND_W-1:0] pend_val;
    logic              ovf_val;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inc     = 1'b0;
        dec     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.pulse_in) begin
                    state_d = HIGH;
                    cnt_d   = HiLoad;
                end
            end
            HIGH: begin
`ifdef PULSE_LEVEL_RETRIGGER_EN
                if (bus.pulse_in) begin
                    cnt_d = HiLoad;
                end else if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GapLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`else
                inc = bus.pulse_in;
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GapLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            GAP: begin
                if (cnt_q == '0) begin
                    // A fresh event here is consumed directly rather than queued.
                    if ((pend_val != '0) || bus.pulse_in) begin
                        state_d = HIGH;
                        cnt_d   = HiLoad;
                    end else begin
                        state_d = IDLE;
                    end
                    dec = (pend_val != '0) && !bus.pulse_in;
                end else begin
                    inc   = bus.pulse_in;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= (state_d == HIGH);
            busy_q  <= (state_d != IDLE);
        end
    end

    pl_sat_cnt #(
        .WIDTH (PEND_W)
    ) u_pend (
        .clk             (clk),
        .rst             (rst),
        .inc             (inc),
        .dec             (dec),
        .value           (pend_val),
        .overflow_sticky (ovf_val)
    );

    assign bus.level_out = level_q;
    assign bus.busy      = busy_q;
    assign bus.pend_cnt  = pend_val;
    assign bus.overflow  = ovf_val;
endmodule

// File: tb/tb_pulse_level_gen.sv
// Self-checking bench for pulse_level_gen: directed tables, hand sequences and random traffic.
module tb_pulse_level_gen;
    localparam int unsigned HI   = 4;
    localparam int unsigned GP   = 2;
    localparam int unsigned PW   = 4;
    localparam int unsigned PMAX = (1 << PW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pulse_level_gen_if #(.PEND_W(PW)) bus ();

    pulse_level_gen #(
        .HIGH_CYCLES (HI),
        .GAP_CYCLES  (GP),
        .PEND_W      (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference: a queue holding the level of every upcoming cycle of the current pulse pattern.
    bit sched[$];
    int m_pend = 0;
    bit m_ovf  = 1'b0;

    function automatic void push_pattern();
        for (int i = 0; i < HI; i++) sched.push_back(1'b1);
        for (int i = 0; i < GP; i++) sched.push_back(1'b0);
    endfunction

    function automatic void model_step(bit p, bit r);
        if (r) begin
            sched.delete();
            m_pend = 0;
            m_ovf  = 1'b0;
        end else if (sched.size() == 0) begin
            if (p) push_pattern();
        end else if (sched.size() == 1) begin
            if (m_pend > 0 || p) push_pattern();
            if (m_pend > 0 && !p) m_pend--;
            void'(sched.pop_front());
`ifdef PULSE_LEVEL_RETRIGGER_EN
        end else if (sched[0] && p) begin
            sched.delete();
            push_pattern();
`endif
        end else begin
            if (p) begin
                if (m_pend == PMAX) m_ovf = 1'b1;
                else m_pend++;
            end
            void'(sched.pop_front());
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit p, input bit r);
        rst = r;
        bus.pulse_in = p;
        @(posedge clk);
        model_step(p, r);
        cyc++;
        #1;
        chk("model_level", 32'(bus.level_out), 32'((sched.size() > 0) && sched[0]));
        chk("model_busy", 32'(bus.busy), 32'(sched.size() > 0));
        chk("model_pend", 32'(bus.pend_cnt), 32'(m_pend));
        chk("model_overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        rst = 1'b0;
        cyc = 0;
    endtask

    typedef struct {
        bit p;
        bit lvl;
        bit bsy;
        int pend;
        bit ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic bit in_rng(int k, int a, int b);
        return (k >= a) && (k <= b);
    endfunction

    task automatic run_table(input string name);
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].p, 1'b0);
            chk({name, "_level"}, 32'(bus.level_out), 32'(tbl[i].lvl));
            chk({name, "_busy"}, 32'(bus.busy), 32'(tbl[i].bsy));
            chk({name, "_pend"}, 32'(bus.pend_cnt), 32'(tbl[i].pend));
            chk({name, "_overflow"}, 32'(bus.overflow), 32'(tbl[i].ovf));
        end
        tbl.delete();
    endtask

    initial begin
        int rises;
        int highs;
        int thresh;
        logic prev;

        bus.pulse_in = 1'b0;
        // Entry k holds the outputs seen in the cycle following rising edge k.
        for (int k = 1; k <= 20; k++)
            tbl.push_back('{(k == 10), in_rng(k, 10, 13), in_rng(k, 10, 15), 0, 1'b0});
        run_table("single");

        for (int k = 1; k <= 24; k++)
            tbl.push_back('{(k == 10 || k == 16), in_rng(k, 10, 13) || in_rng(k, 16, 19),
                            in_rng(k, 10, 21), 0, 1'b0});
        run_table("last_gap");

`ifndef PULSE_LEVEL_RETRIGGER_EN
        for (int k = 1; k <= 32; k++)
            tbl.push_back('{(k == 10 || k == 12 || k == 13),
                            in_rng(k, 10, 13) || in_rng(k, 16, 19) || in_rng(k, 22, 25),
                            in_rng(k, 10, 27),
                            (k < 12) ? 0 : (k == 12) ? 1 : (k < 16) ? 2 : (k < 22) ? 1 : 0,
                            1'b0});
        run_table("queued");

        do_reset();
        for (int k = 1; k <= 29; k++) step(k >= 10, 1'b0);
        chk("sat_pend", 32'(bus.pend_cnt), 32'(PMAX));
        chk("sat_overflow", 32'(bus.overflow), 32'd1);
        rises = 0;
        prev  = bus.level_out;
        for (int i = 0; i < 200 && bus.busy; i++) begin
            step(1'b0, 1'b0);
            if (bus.level_out && !prev) rises++;
            prev = bus.level_out;
        end
        chk("drain_replays", 32'(rises), 32'd15);
        chk("drain_busy", 32'(bus.busy), 32'd0);
        chk("drain_pend", 32'(bus.pend_cnt), 32'd0);
        chk("drain_overflow", 32'(bus.overflow), 32'd1);
`else
        for (int k = 1; k <= 22; k++)
            tbl.push_back('{(k == 10 || k == 13), in_rng(k, 10, 16), in_rng(k, 10, 18), 0, 1'b0});
        run_table("retrigger");
`endif

        do_reset();
        for (int k = 1; k <= 12; k++) step((k == 10 || k == 11), (k == 12));
        rst = 1'b0;
        chk("rst_level", 32'(bus.level_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_pend", 32'(bus.pend_cnt), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0);
            if (bus.level_out) highs++;
        end
        chk("rst_no_replay", 32'(highs), 32'd0);

        do_reset();
        for (int blk = 0; blk < 9; blk++) begin
            thresh = (blk % 3 == 0) ? 10 : (blk % 3 == 1) ? 40 : 90;
            for (int k = 0; k < 100; k++)
                step(($urandom_range(0, 99) < thresh), ($urandom_range(0, 299) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
